// File: rtl/mem_lsu_split.sv
// mem_lsu_split: load/store unit between execute and a single-port data bus.
// Latches each request, aligns every bus address, splits word-crossing
// accesses into two beats (merging load data), and faults illegal accesses.

package core_pkg;
    typedef enum logic [1:0] {
        MemNone  = 2'd0,
        MemLoad  = 2'd1,
        MemStore = 2'd2
    } mem_type_e;
endpackage

module mem_lsu_split #(
    parameter int Xlen            = 32,
    parameter int MaskBits        = Xlen / 8,
    parameter bit SplitMisaligned = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_inst_i,
    input  logic [1:0]          mem_type_i,
    input  logic [Xlen-1:0]     addr_i,
    input  logic [Xlen-1:0]     wdata_i,
    input  logic [2:0]          funct3_i,
    output logic [Xlen-1:0]     rdata_o,
    output logic                mem_busy_o,
    output logic                done_o,
    output logic                fault_o,
    input  logic                mem_ready_i,
    output logic                mem_valid_o,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i
);

    localparam int B    = MaskBits;
    localparam int OffW = $clog2(B);
    localparam logic [Xlen-1:0] BeatBytes = Xlen'(B);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ0 = 3'd1;
    localparam logic [2:0] RSP0 = 3'd2;
    localparam logic [2:0] REQ1 = 3'd3;
    localparam logic [2:0] RSP1 = 3'd4;

    logic [2:0]      state;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [OffW-1:0] off_q;
    logic [3:0]      size_q;
    logic [Xlen-1:0] base_q;
    logic            split_q;
    logic [Xlen-1:0] wdata0_q;
    logic [Xlen-1:0] wdata1_q;
    logic [B-1:0]    wmask0_q;
    logic [B-1:0]    wmask1_q;
    logic [Xlen-1:0] beat0_q;

    // request decode signals
    logic            is_store;
    logic [OffW-1:0] off;
    logic [3:0]      size_bytes;
    logic [4:0]      end_pos;
    logic            crosses;
    logic            illegal;
    logic            req;
    logic            accept;
    logic            fault;
    logic [B-1:0]    lane_en;
    logic [2*B-1:0]  mask_wide;
    logic [2*Xlen-1:0] data_wide;

    // response path signals
    logic            rsp_fire;
    logic            finish;
    logic [31:0]     hi_sh;
    logic [Xlen-1:0] raw;
    logic [Xlen-1:0] keep;
    logic            sign;
    logic [Xlen-1:0] ext;

    // Decode the incoming request: size, offset, legality and lane placement
    // of both beats (a double-width shift gives beat 0 low, beat 1 high).
    always_comb begin
        is_store   = (mem_type_i == core_pkg::MemStore);
        off        = addr_i[OffW-1:0];
        size_bytes = 4'd1 << funct3_i[1:0];
        end_pos    = 5'(off) + 5'(size_bytes);
        crosses    = (end_pos > 5'(B));
        illegal    = (funct3_i == 3'd7)
                   || ((Xlen == 32) && ((funct3_i == 3'd3) || (funct3_i == 3'd6)))
                   || (is_store && funct3_i[2])
                   || (crosses && !SplitMisaligned);
        req        = (state == IDLE) && valid_inst_i && (mem_type_i != core_pkg::MemNone);
        accept     = req && !illegal;
        fault      = req && illegal;
        for (int unsigned i = 0; i < B; i++) begin
            lane_en[i] = (i < 32'(size_bytes));
        end
        mask_wide  = {{B{1'b0}}, lane_en} << off;
        data_wide  = {{Xlen{1'b0}}, wdata_i} << {off, 3'b000};
    end

    // Load data: align beat 0, merge beat 1 above it, trim to size and extend.
    always_comb begin
        rsp_fire = ((state == RSP0) || (state == RSP1)) && mem_rvalid_i;
        finish   = rsp_fire && ((state == RSP1) || !split_q);
        hi_sh    = (32'(B) - 32'(off_q)) << 3;
        if (state == RSP1) begin
            raw = beat0_q | (mem_rdata_i << hi_sh);
        end else begin
            raw = mem_rdata_i >> {off_q, 3'b000};
        end
        keep = '0;
        for (int unsigned i = 0; i < B; i++) begin
            keep[8*i +: 8] = {8{i < 32'(size_q)}};
        end
        case (funct3_q[1:0])
            2'd0:    sign = raw[7];
            2'd1:    sign = raw[15];
            2'd2:    sign = raw[31];
            default: sign = raw[Xlen-1];
        endcase
        ext = (raw & keep) | ((!funct3_q[2] && sign) ? ~keep : '0);
    end

    // Drive the bus request and pipeline handshake outputs from the state.
    always_comb begin
        mem_valid_o = (state == REQ0) || (state == REQ1);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (state == REQ0) begin
            mem_addr_o  = base_q;
            mem_wdata_o = wdata0_q;
            mem_wmask_o = wmask0_q;
        end else if (state == REQ1) begin
            mem_addr_o  = base_q + BeatBytes;
            mem_wdata_o = wdata1_q;
            mem_wmask_o = wmask1_q;
        end
        done_o     = finish || fault;
        fault_o    = fault;
        mem_busy_o = accept || ((state != IDLE) && !finish);
        rdata_o    = (finish && !is_store_q) ? ext : '0;
    end

    // Sequencer: latch the request on accept, then walk the beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            size_q     <= '0;
            base_q     <= '0;
            split_q    <= 1'b0;
            wdata0_q   <= '0;
            wdata1_q   <= '0;
            wmask0_q   <= '0;
            wmask1_q   <= '0;
            beat0_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3_i;
                        off_q      <= off;
                        size_q     <= size_bytes;
                        base_q     <= {addr_i[Xlen-1:OffW], {OffW{1'b0}}};
                        split_q    <= crosses;
                        wdata0_q   <= is_store ? data_wide[Xlen-1:0] : '0;
                        wdata1_q   <= is_store ? data_wide[2*Xlen-1:Xlen] : '0;
                        wmask0_q   <= is_store ? mask_wide[B-1:0] : '0;
                        wmask1_q   <= is_store ? mask_wide[2*B-1:B] : '0;
                        state      <= REQ0;
                    end
                end
                REQ0: if (mem_ready_i) state <= RSP0;
                RSP0: begin
                    if (mem_rvalid_i) begin
                        if (split_q) begin
                            beat0_q <= raw;
                            state   <= REQ1;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                REQ1: if (mem_ready_i) state <= RSP1;
                RSP1: if (mem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu_split.sv
// tb_mem_lsu_split: directed vector table, hand-written reset/back-pressure
// sequences, and randomized operations checked against a byte-level model.

module tb_mem_lsu_split;

    localparam logic [1:0] T_LD = core_pkg::MemLoad;
    localparam logic [1:0] T_ST = core_pkg::MemStore;

    logic        clk, rst_n, valid_inst, sel;
    logic [1:0]  mem_type;
    logic [31:0] addr, wdata, mem_rdata;
    logic [2:0]  funct3;
    logic        mem_ready, mem_rvalid;

    logic        valid_a, valid_b;
    logic [31:0] rdata_a, rdata_b, maddr_a, maddr_b, mwdata_a, mwdata_b;
    logic [3:0]  mwmask_a, mwmask_b;
    logic        busy_a, busy_b, done_a, done_b, fault_a, fault_b, mvalid_a, mvalid_b;

    logic [31:0] rdata_s, maddr_s, mwdata_s;
    logic [3:0]  mwmask_s;
    logic        busy_s, done_s, fault_s, mvalid_s;

    int checks = 0;
    int errors = 0;

    assign valid_a  = valid_inst & ~sel;
    assign valid_b  = valid_inst & sel;
    assign rdata_s  = sel ? rdata_b  : rdata_a;
    assign maddr_s  = sel ? maddr_b  : maddr_a;
    assign mwdata_s = sel ? mwdata_b : mwdata_a;
    assign mwmask_s = sel ? mwmask_b : mwmask_a;
    assign busy_s   = sel ? busy_b   : busy_a;
    assign done_s   = sel ? done_b   : done_a;
    assign fault_s  = sel ? fault_b  : fault_a;
    assign mvalid_s = sel ? mvalid_b : mvalid_a;

    mem_lsu_split #(.Xlen(32), .MaskBits(4), .SplitMisaligned(1'b1)) u_split (
        .clk_i(clk), .rst_ni(rst_n), .valid_inst_i(valid_a), .mem_type_i(mem_type),
        .addr_i(addr), .wdata_i(wdata), .funct3_i(funct3), .rdata_o(rdata_a),
        .mem_busy_o(busy_a), .done_o(done_a), .fault_o(fault_a),
        .mem_ready_i(mem_ready), .mem_valid_o(mvalid_a), .mem_addr_o(maddr_a),
        .mem_wdata_o(mwdata_a), .mem_wmask_o(mwmask_a), .mem_rdata_i(mem_rdata),
        .mem_rvalid_i(mem_rvalid));

    mem_lsu_split #(.Xlen(32), .MaskBits(4), .SplitMisaligned(1'b0)) u_nosplit (
        .clk_i(clk), .rst_ni(rst_n), .valid_inst_i(valid_b), .mem_type_i(mem_type),
        .addr_i(addr), .wdata_i(wdata), .funct3_i(funct3), .rdata_o(rdata_b),
        .mem_busy_o(busy_b), .done_o(done_b), .fault_o(fault_b),
        .mem_ready_i(mem_ready), .mem_valid_o(mvalid_b), .mem_addr_o(maddr_b),
        .mem_wdata_o(mwdata_b), .mem_wmask_o(mwmask_b), .mem_rdata_i(mem_rdata),
        .mem_rvalid_i(mem_rvalid));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fault_t, done_t, busy_t;
        int          beats;
        logic [31:0] addr0, addr1, wd0, wd1;
        logic [3:0]  mk0, mk1;
        logic [31:0] rdata;
        int          cycles;
        logic        proto_ok, timeout;
    } obs_t;

    typedef struct {
        logic        sel;
        logic [1:0]  t;
        logic [2:0]  f3;
        logic [31:0] a, wd, r0, r1;
        logic        fault;
        int          beats;
        logic [31:0] addr0;
        logic [3:0]  mk0;
        logic [31:0] wd0, addr1;
        logic [3:0]  mk1;
        logic [31:0] wd1, rdata;
        int          cycles;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Byte-level reference: bytes off..off+S-1 of the access map onto
    // consecutive bus lanes, spilling into the next word when they cross.
    function automatic obs_t model(input logic [1:0] t, input logic [2:0] f3,
                                   input logic [31:0] a, wd, r0, r1,
                                   input int rw, sw, input logic split_en);
        obs_t e;
        int s, off, p;
        logic st;
        logic [63:0] v;
        e = '{default: 0};
        e.proto_ok = 1'b1;
        st  = (t == T_ST);
        s   = 1 << f3[1:0];
        off = int'(a[1:0]);
        if (f3 == 3'd7 || f3 == 3'd3 || f3 == 3'd6 || (st && f3 >= 3'd4) ||
            (off + s > 4 && !split_en)) begin
            e.fault_t = 1'b1;
            e.done_t  = 1'b1;
            return e;
        end
        e.busy_t = 1'b1;
        e.beats  = (off + s > 4) ? 2 : 1;
        e.addr0  = {a[31:2], 2'b00};
        e.addr1  = e.addr0 + 32'd4;
        if (st) begin
            for (int j = 0; j < 4; j++) begin
                p = off + j;
                if (p < 4) e.wd0[8*p +: 8] = wd[8*j +: 8];
                else       e.wd1[8*(p-4) +: 8] = wd[8*j +: 8];
            end
            for (int i = 0; i < s; i++) begin
                p = off + i;
                if (p < 4) e.mk0[p] = 1'b1;
                else       e.mk1[p-4] = 1'b1;
            end
        end else begin
            v = '0;
            for (int i = 0; i < s; i++) begin
                p = off + i;
                v[8*i +: 8] = (p < 4) ? r0[8*p +: 8] : r1[8*(p-4) +: 8];
            end
            if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~((64'd1 << (8*s)) - 64'd1);
            e.rdata = v[31:0];
        end
        e.cycles = e.beats * (2 + rw + sw);
        return e;
    endfunction

    // Issue one request and act as the bus: rw cycles of ready back-pressure
    // per beat, rvalid sw cycles after each handshake, stray rvalids while no
    // response is owed, and garbage on the request inputs once accepted.
    task automatic run_op(input logic [1:0] t, input logic [2:0] f3,
                          input logic [31:0] a, wd, r0, r1,
                          input int rw, sw, output obs_t o);
        int cnt_r, cnt_s, idx;
        logic pending, seen;
        o = '{default: 0};
        o.proto_ok = 1'b1;
        o.timeout  = 1'b1;
        @(negedge clk);
        valid_inst = 1'b1; mem_type = t; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        o.fault_t = fault_s; o.done_t = done_s; o.busy_t = busy_s;
        if (rdata_s != 32'd0 || mvalid_s) o.proto_ok = 1'b0;
        if (fault_s) begin
            o.timeout = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                valid_inst = 1'b0;
                #1;
                if (mvalid_s) o.beats++;
                if (done_s || fault_s || busy_s) o.proto_ok = 1'b0;
            end
            return;
        end
        pending = 1'b0; seen = 1'b0; cnt_r = rw; cnt_s = 0; idx = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            valid_inst = 1'($urandom); mem_type = 2'($urandom);
            funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (pending && cnt_s == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (idx == 0) ? r0 : r1;
            end else if (!pending && ($urandom % 4 == 0)) begin
                mem_rvalid = 1'b1;
            end
            if (mvalid_s) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (o.beats == 0) begin o.addr0 = maddr_s; o.mk0 = mwmask_s; o.wd0 = mwdata_s; end
                    else begin o.addr1 = maddr_s; o.mk1 = mwmask_s; o.wd1 = mwdata_s; end
                end else if (o.beats == 0) begin
                    if (o.addr0 != maddr_s || o.mk0 != mwmask_s || o.wd0 != mwdata_s) o.proto_ok = 1'b0;
                end else begin
                    if (o.addr1 != maddr_s || o.mk1 != mwmask_s || o.wd1 != mwdata_s) o.proto_ok = 1'b0;
                end
                if (cnt_r == 0) mem_ready = 1'b1;
                else cnt_r--;
            end
            #1;
            if (fault_s) o.proto_ok = 1'b0;
            if (done_s) begin
                o.rdata = rdata_s; o.cycles = cyc; o.timeout = 1'b0;
                if (busy_s) o.proto_ok = 1'b0;
                valid_inst = 1'b0;
                break;
            end
            if (!busy_s || rdata_s != 32'd0) o.proto_ok = 1'b0;
            if (mem_ready && mvalid_s) begin
                pending = 1'b1; cnt_s = sw; o.beats++; seen = 1'b0;
            end else if (pending && mem_rvalid) begin
                pending = 1'b0; idx++; cnt_r = rw;
            end else if (pending) begin
                cnt_s--;
            end
        end
        valid_inst = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e, input logic st);
        chk({tag, ".fault"}, 64'(o.fault_t), 64'(e.fault_t));
        chk({tag, ".done_t"}, 64'(o.done_t), 64'(e.done_t));
        chk({tag, ".busy_t"}, 64'(o.busy_t), 64'(e.busy_t));
        chk({tag, ".beats"}, 64'(o.beats), 64'(e.beats));
        chk({tag, ".proto"}, 64'(o.proto_ok), 64'(1'b1));
        chk({tag, ".timeout"}, 64'(o.timeout), 64'(1'b0));
        if (!e.fault_t) begin
            chk({tag, ".cycles"}, 64'(o.cycles), 64'(e.cycles));
            chk({tag, ".addr0"}, 64'(o.addr0), 64'(e.addr0));
            chk({tag, ".mask0"}, 64'(o.mk0), 64'(e.mk0));
            if (st) chk({tag, ".wdata0"}, 64'(o.wd0), 64'(e.wd0));
            if (e.beats == 2) begin
                chk({tag, ".addr1"}, 64'(o.addr1), 64'(e.addr1));
                chk({tag, ".mask1"}, 64'(o.mk1), 64'(e.mk1));
                if (st) chk({tag, ".wdata1"}, 64'(o.wd1), 64'(e.wd1));
            end
            chk({tag, ".rdata"}, 64'(o.rdata), 64'(e.rdata));
        end
    endtask

    vec_t vec[16];
    obs_t o, e;
    logic ok;
    logic [1:0] rt;
    logic [2:0] rf;
    logic [31:0] ra, rwd, rr0, rr1;
    int rw_r, sw_r;

    initial begin
        rst_n = 1'b0; sel = 1'b0; valid_inst = 1'b0; mem_type = 2'd0; funct3 = 3'd0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;

        //         sel  type  f3    addr         wdata        rd0          rd1          flt beats addr0  mk0   wd0          addr1  mk1   wd1          rdata        cyc
        vec[0]  = '{1'b0, T_LD, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0,       1'b0, 1, 32'h100, 4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'hDEADBEEF, 2};
        vec[1]  = '{1'b0, T_LD, 3'd1, 32'h101, 32'h0,        32'h0080FF00, 32'h0,       1'b0, 1, 32'h100, 4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'hFFFF80FF, 2};
        vec[2]  = '{1'b0, T_LD, 3'd5, 32'h101, 32'h0,        32'h0080FF00, 32'h0,       1'b0, 1, 32'h100, 4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h000080FF, 2};
        vec[3]  = '{1'b0, T_ST, 3'd2, 32'h103, 32'h11223344, 32'h0,        32'h0,       1'b0, 2, 32'h100, 4'h8, 32'h44000000, 32'h104, 4'h7, 32'h00112233, 32'h0,      4};
        vec[4]  = '{1'b0, T_LD, 3'd2, 32'h102, 32'h0,        32'hAABB1234, 32'h5678CCDD, 1'b0, 2, 32'h100, 4'h0, 32'h0,      32'h104, 4'h0, 32'h0,       32'hCCDDAABB, 4};
        vec[5]  = '{1'b0, T_LD, 3'd3, 32'h100, 32'h0,        32'h0,        32'h0,       1'b1, 0, 32'h0,   4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h0,        0};
        vec[6]  = '{1'b1, T_ST, 3'd1, 32'h103, 32'h0000BEEF, 32'h0,        32'h0,       1'b1, 0, 32'h0,   4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h0,        0};
        vec[7]  = '{1'b1, T_LD, 3'd2, 32'h100, 32'h0,        32'h13579BDF, 32'h0,       1'b0, 1, 32'h100, 4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h13579BDF, 2};
        vec[8]  = '{1'b0, T_ST, 3'd0, 32'h007, 32'h000000A5, 32'h0,        32'h0,       1'b0, 1, 32'h004, 4'h8, 32'hA5000000, 32'h0,   4'h0, 32'h0,       32'h0,        2};
        vec[9]  = '{1'b0, T_LD, 3'd0, 32'h002, 32'h0,        32'h00800000, 32'h0,       1'b0, 1, 32'h000, 4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'hFFFFFF80, 2};
        vec[10] = '{1'b0, T_LD, 3'd4, 32'h002, 32'h0,        32'h00800000, 32'h0,       1'b0, 1, 32'h000, 4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h00000080, 2};
        vec[11] = '{1'b0, T_ST, 3'd4, 32'h010, 32'h12345678, 32'h0,        32'h0,       1'b1, 0, 32'h0,   4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h0,        0};
        vec[12] = '{1'b0, T_LD, 3'd7, 32'h010, 32'h0,        32'h0,        32'h0,       1'b1, 0, 32'h0,   4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h0,        0};
        vec[13] = '{1'b0, T_ST, 3'd1, 32'h103, 32'h0000BEEF, 32'h0,        32'h0,       1'b0, 2, 32'h100, 4'h8, 32'hEF000000, 32'h104, 4'h1, 32'h000000BE, 32'h0,      4};
        vec[14] = '{1'b0, T_LD, 3'd5, 32'h003, 32'h0,        32'h12000000, 32'h00000034, 1'b0, 2, 32'h000, 4'h0, 32'h0,      32'h004, 4'h0, 32'h0,       32'h00003412, 4};
        vec[15] = '{1'b0, T_LD, 3'd6, 32'h020, 32'h0,        32'h0,        32'h0,       1'b1, 0, 32'h0,   4'h0, 32'h0,       32'h0,   4'h0, 32'h0,       32'h0,        0};

        // reset state, sampled while reset is still asserted
        #12;
        chk("rst.valid", 64'(mvalid_a), 64'd0);
        chk("rst.busy", 64'(busy_a), 64'd0);
        chk("rst.done", 64'(done_a | fault_a), 64'd0);
        chk("rst.addr", 64'(maddr_a), 64'd0);
        chk("rst.wdata", 64'(mwdata_a), 64'd0);
        chk("rst.wmask", 64'(mwmask_a), 64'd0);
        chk("rst.rdata", 64'(rdata_a), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            sel = vec[i].sel;
            run_op(vec[i].t, vec[i].f3, vec[i].a, vec[i].wd, vec[i].r0, vec[i].r1, 0, 0, o);
            e = '{default: 0};
            e.fault_t = vec[i].fault; e.done_t = vec[i].fault; e.busy_t = !vec[i].fault;
            e.beats = vec[i].beats; e.addr0 = vec[i].addr0; e.mk0 = vec[i].mk0; e.wd0 = vec[i].wd0;
            e.addr1 = vec[i].addr1; e.mk1 = vec[i].mk1; e.wd1 = vec[i].wd1;
            e.rdata = vec[i].rdata; e.cycles = vec[i].cycles; e.proto_ok = 1'b1;
            compare($sformatf("vec%0d", i), o, e, vec[i].t == T_ST);
        end
        sel = 1'b0;

        // back-pressure on a split store
        run_op(T_ST, 3'd2, 32'h203, 32'hCAFEF00D, 32'h0, 32'h0, 5, 2, o);
        compare("bp_split_sw", o, model(T_ST, 3'd2, 32'h203, 32'hCAFEF00D, 32'h0, 32'h0, 5, 2, 1'b1), 1'b1);

        // request held 5 cycles without ready, then reset while it is pending
        @(negedge clk);
        valid_inst = 1'b1; mem_type = T_LD; funct3 = 3'd2; addr = 32'h200;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        valid_inst = 1'b0; addr = $urandom;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (!(mvalid_a && maddr_a == 32'h200 && mwmask_a == 4'h0 && busy_a)) ok = 1'b0;
            @(negedge clk);
        end
        chk("hold.stable", 64'(ok), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req.valid", 64'(mvalid_a), 64'd0);
        chk("rst_req.addr", 64'(maddr_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset while waiting for the response; a late rvalid must be ignored
        @(negedge clk);
        valid_inst = 1'b1; mem_type = T_LD; funct3 = 3'd2; addr = 32'h300;
        @(negedge clk);
        valid_inst = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp.valid", 64'(mvalid_a), 64'd0);
        chk("rst_rsp.busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
        #1;
        chk("stray.done", 64'(done_a), 64'd0);
        chk("stray.rdata", 64'(rdata_a), 64'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("stray.idle", 64'(mvalid_a | busy_a), 64'd0);
        run_op(T_LD, 3'd2, 32'h104, 32'h0, 32'h01234567, 32'h0, 0, 0, o);
        compare("after_rst_lw", o, model(T_LD, 3'd2, 32'h104, 32'h0, 32'h01234567, 32'h0, 0, 0, 1'b1), 1'b0);

        // randomized operations on both configurations
        for (int n = 0; n < 200; n++) begin
            sel  = 1'($urandom);
            rt   = ($urandom % 2 == 0) ? T_LD : T_ST;
            rf   = 3'($urandom);
            ra   = $urandom & 32'h0000_0FFF;
            rwd  = $urandom; rr0 = $urandom; rr1 = $urandom;
            rw_r = int'($urandom_range(0, 3));
            sw_r = int'($urandom_range(0, 3));
            run_op(rt, rf, ra, rwd, rr0, rr1, rw_r, sw_r, o);
            compare($sformatf("rnd%0d", n), o, model(rt, rf, ra, rwd, rr0, rr1, rw_r, sw_r, !sel), rt == T_ST);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu_split.md
# mem_lsu_split

Parametrised load/store unit between the execute stage and the single-port data-memory bus. It accepts one load or store per request and drives a ready/valid request channel with an rvalid response. Relative to the first-generation LSU it adds these behaviours:
- widths are parameterised (Xlen 32 or 64);
- all bus addresses are aligned;
- request attributes are latched, so no inputs need to be held;
- accesses that cross a bus word are split into two beats, and loads are merged;
- illegal or disallowed misaligned accesses raise a fault.

## Interface
Parameters:
- Xlen, 32, data/address width; legal values 32 or 64.
- MaskBits, Xlen/8, byte-enable width (B bytes per bus word).
- SplitMisaligned, 1, 1 = split word-crossing accesses into two beats; 0 = fault them.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- valid_inst_i  in  1  request strobe; only sampled in Idle.
- mem_type_i  in  2  MemNone / MemLoad / MemStore (core_pkg).
- addr_i  in  Xlen  byte address.
- wdata_i  in  Xlen  store data, right-aligned.
- funct3_i  in  3  RISC-V size/sign: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU.
- rdata_o  out  Xlen  extended load data; valid only in the done cycle of a load, 0 otherwise.
- mem_busy_o  out  1  stall request to the pipeline.
- done_o  out  1  one-cycle completion pulse.
- fault_o  out  1  one-cycle fault pulse.
- mem_ready_i  in  1  bus accepts request.
- mem_valid_o  out  1  bus request valid.
- mem_addr_o  out  Xlen  aligned address; low log2(B) bits always 0.
- mem_wdata_o  out  Xlen  lane-positioned store data.
- mem_wmask_o  out  MaskBits  byte enables; 0 for loads.
- mem_rdata_i  in  Xlen  bus word read data.
- mem_rvalid_i  in  1  response for the oldest accepted beat; loads and stores both get one.

## Operation
- Size S = 1 << funct3[1:0]; offset off = addr[log2(B)-1:0]; base = addr with offset cleared.
- Single-beat access: off + S <= B. Split access: off + S > B.
- Illegal access, which raises a fault:
  - funct3 = 7;
  - funct3 = 3 or 6 when Xlen = 32;
  - store with funct3 >= 4;
  - split access with SplitMisaligned = 0.
- Fault behaviour: detected in Idle in the accept cycle; fault_o and done_o pulse combinationally; mem_busy_o = 0; no bus transaction; state stays Idle.
- Accept, in Idle when valid_inst_i and mem_type_i != MemNone and the access is legal:
  - mem_busy_o = 1 combinationally;
  - latch type, funct3, off, S, base, split flag, both beats' wdata/wmask;
  - go to Req0.
- Beat 0 request: address = base, wmask = ((1<<S)-1) << off truncated to B bits, wdata = wdata_i << 8*off.
- Beat 1 request: address = base + B, wmask = ((1<<S)-1) >> (B-off), wdata = wdata_i >> 8*(B-off).
- FSM states and transitions:
  - Req0: mem_valid_o = 1; on mem_ready_i go to Rsp0.
  - Rsp0: on mem_rvalid_i, either finish (single beat) or store the shifted rdata_i >> 8*off and go to Req1 (split).
  - Req1: mem_valid_o = 1; on mem_ready_i go to Rsp1.
  - Rsp1: on mem_rvalid_i, finish.
- Finish: done_o = 1 and mem_busy_o = 0 in the cycle of the last rvalid; next state Idle.
- mem_busy_o = 1 in all non-Idle cycles except the finish cycle.
- Load merge (split case): merged = beat0_reg | (mem_rdata_i << 8*(B-off)), masked to S bytes.
- Load extension: zero-extend when funct3[2] = 1, otherwise sign-extend from bit 8*S-1. D loads pass through unextended.
- Ignored inputs: valid_inst_i outside Idle; mem_rvalid_i in Idle and Req states.

## Timing
- Reset, asynchronous: state Idle, all latches 0. mem_valid_o, done_o, fault_o, mem_wmask_o, mem_addr_o, mem_wdata_o and rdata_o are 0.
- mem_valid_o drops in the same instant rst_ni falls. Reset mid-transaction abandons it; a late rvalid afterwards is ignored.
- Bus guarantee: rvalid comes at the earliest one cycle after the ready handshake.
- Single-beat latency with a zero-wait bus: accept T, handshake T+1, done T+2.
- Split latency with a zero-wait bus: done T+4.
- Held-valid rule: mem_valid_o, mem_addr_o, mem_wdata_o and mem_wmask_o stay stable until mem_ready_i. mem_valid_o is never withdrawn without a handshake.
- Back-to-back requests: a new request can be accepted in the cycle after done. Idle accept is gated only by state, not by done_o.

## Test plan
- LW at 0x100 (Xlen=32), rdata_i 0xDEADBEEF -> mem_addr_o 0x100, wmask 0, rdata_o 0xDEADBEEF with done_o at T+2.
- LH at 0x101, rdata_i 0x0080FF00 -> single beat, rdata_o 0xFFFF80FF. LHU same stimulus -> 0x000080FF.
- SW 0x11223344 at 0x103 -> beat0: addr 0x100, wmask 1000, wdata 0x44000000. Beat1: addr 0x104, wmask 0111, wdata 0x00112233. done_o at T+4.
- LW at 0x102, beat0 rdata 0xAABB1234, beat1 rdata 0x5678CCDD -> rdata_o 0xCCDDAABB. mem_busy_o high T..T+3, low at T+4.
- Faults:
  - SplitMisaligned=0, SH at 0x103 -> fault_o and done_o pulse at T, mem_valid_o never asserted.
  - LD (funct3=3) at Xlen=32 -> same fault response.
- Back-pressure and reset:
  - mem_ready_i low for 5 cycles -> request outputs stable throughout.
  - rst_ni low during Rsp0 -> mem_valid_o 0 immediately; a following stray rvalid is ignored; the next LW completes normally.
